// File: rtl/sr_ff_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sr_ff_bank
// Description : Bank of N independent storage bits. Each bit acts as an SR,
//               JK, D or T flip-flop selected by a shared mode input. SR-mode
//               S=R=1 resolves deterministically (CONFLICT_POL) and is logged
//               in sticky per-channel flags and a saturating event counter.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               en[N]      - per-channel update enable
//               mode[2]    - 00 SR, 01 JK, 10 D, 11 T
//               s[N]       - S / J / D / T input
//               r[N]       - R / K input (ignored in D and T modes)
//               err_clr    - synchronous clear of err_sticky / err_cnt
//               q[N]       - registered state
//               qbar[N]    - registered complement of q
//               changed[N] - one-cycle pulse, q bit changed on last edge
//               err_sticky - per-channel sticky SR-conflict flag
//               err_cnt    - saturating count of edges with any conflict
// Revision    : 1.0 - initial release
// ============================================================================
module sr_ff_bank #(
    parameter int             N            = 8,
    parameter logic [N-1:0]   RESET_VAL    = {N{1'b0}},
    parameter int             CONFLICT_POL = 0,
    parameter int             CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     en,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic             err_clr,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qbar,
    output logic [N-1:0]     changed,
    output logic [N-1:0]     err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0]       c_MODE_SR = 2'b00;
    localparam logic [1:0]       c_MODE_JK = 2'b01;
    localparam logic [1:0]       c_MODE_D  = 2'b10;
    localparam logic [1:0]       c_MODE_T  = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Reject illegal parameterisations at elaboration time.
    if (CONFLICT_POL < 0 || CONFLICT_POL > 2) begin : g_bad_conflict_pol
        $error("sr_ff_bank: CONFLICT_POL must be 0, 1 or 2");
    end
    if (N < 1 || N > 64) begin : g_bad_n
        $error("sr_ff_bank: N must be in 1..64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sr_ff_bank: CNT_W must be at least 1");
    end

    logic [N-1:0]     r_q;
    logic [N-1:0]     r_qbar;
    logic [N-1:0]     r_changed;
    logic [N-1:0]     r_sticky;
    logic [CNT_W-1:0] r_cnt;

    logic [N-1:0]     w_q_next;
    logic [N-1:0]     w_conflict;
    logic [N-1:0]     w_sticky_next;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;

    // Per-channel next-state; disabled channels hold and never flag a conflict.
    always_comb begin
        w_q_next   = r_q;
        w_conflict = '0;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                case (mode)
                    c_MODE_SR: begin
                        case ({s[i], r[i]})
                            2'b01:   w_q_next[i] = 1'b0;
                            2'b10:   w_q_next[i] = 1'b1;
                            2'b11: begin
                                w_conflict[i] = 1'b1;
                                if (CONFLICT_POL == 1)
                                    w_q_next[i] = 1'b0;
                                else if (CONFLICT_POL == 2)
                                    w_q_next[i] = 1'b1;
                                else
                                    w_q_next[i] = r_q[i];
                            end
                            default: w_q_next[i] = r_q[i];
                        endcase
                    end
                    c_MODE_JK: begin
                        case ({s[i], r[i]})
                            2'b01:   w_q_next[i] = 1'b0;
                            2'b10:   w_q_next[i] = 1'b1;
                            2'b11:   w_q_next[i] = ~r_q[i];
                            default: w_q_next[i] = r_q[i];
                        endcase
                    end
                    c_MODE_D: w_q_next[i] = s[i];
                    c_MODE_T: w_q_next[i] = r_q[i] ^ s[i];
                    default:  w_q_next[i] = r_q[i];
                endcase
            end
        end
    end

    // Clear is applied before the new event, so a simultaneous clear and
    // conflict leaves exactly this edge's conflicts recorded.
    always_comb begin
        w_sticky_next = (err_clr ? '0 : r_sticky) | w_conflict;
        w_cnt_base    = err_clr ? '0 : r_cnt;
        w_cnt_next    = w_cnt_base;
        if ((|w_conflict) && (w_cnt_base != c_CNT_MAX))
            w_cnt_next = w_cnt_base + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= RESET_VAL;
            r_qbar    <= ~RESET_VAL;
            r_changed <= '0;
            r_sticky  <= '0;
            r_cnt     <= '0;
        end else begin
            r_q       <= w_q_next;
            r_qbar    <= ~w_q_next;
            r_changed <= en & (w_q_next ^ r_q);
            r_sticky  <= w_sticky_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign q          = r_q;
    assign qbar       = r_qbar;
    assign changed    = r_changed;
    assign err_sticky = r_sticky;
    assign err_cnt    = r_cnt;

endmodule
`default_nettype wire
